// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit and its FIFOs.
package fetch_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int ILEN_BYTES   = 4;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] instr;
  } fq_entry_t;

  // Sequential fetch address; wraps modulo 2^XLEN.
  function automatic logic [DEFAULT_XLEN-1:0] next_pc(input logic [DEFAULT_XLEN-1:0] pc);
    return pc + DEFAULT_XLEN'(ILEN_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count, used for the fetch queue and the request-PC tags.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign doPop   = pop & (count != '0);
  assign doPush  = push & ((count != CW'(DEPTH)) | doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush && !flush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Flush empties the FIFO and wins over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= bump(wrPtr);
      if (doPop)  rdPtr <= bump(rdPtr);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

endmodule

// File: rtl/fetch_unit_q.sv
// Instruction fetch unit: PC, credit-based imem requests, fetch queue, redirect flush.
// Define FETCH_PERF_CNT_EN to add saturating fetch/flush performance counters.
module fetch_unit_q
  import fetch_pkg::*;
#(
  parameter int              XLEN      = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCtargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_validD,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCplus4D,
  input  logic            stallD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetchedD,
  output logic [31:0]     perf_flushedD
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;

  logic [XLEN-1:0] pcF;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   dropCnt;
  logic [CW-1:0]   fqCount;
  logic [OW-1:0]   tagCount;
  logic [CW:0]     creditUsed;
  logic [XLEN-1:0] tagPc;
  fq_entry_t       fqIn;
  fq_entry_t       fqHead;
  logic            reqFire;
  logic            rspCounted;
  logic            rspKeep;
  logic            rspDrop;
  logic            fqPop;
  logic            unusedTgtBits;

  // Credit check uses registered state only, so every accepted request owns a queue slot.
  assign creditUsed     = (CW+1)'(fqCount) + (CW+1)'(outstanding);
  assign imem_req_valid = ~reset & (creditUsed < (CW+1)'(FQ_DEPTH)) & (outstanding < OW'(MAX_OUTST));
  assign imem_req_addr  = pcF;
  assign reqFire        = imem_req_valid & imem_req_ready;

  assign rspCounted = imem_rsp_valid & (outstanding != '0);
  assign rspDrop    = rspCounted & (PCSrcE | (dropCnt != '0));
  assign rspKeep    = rspCounted & ~PCSrcE & (dropCnt == '0) & (tagCount != '0);
  assign fqPop      = instr_validD & ~stallD & ~PCSrcE;
  assign fqIn       = '{pc: tagPc, instr: imem_rsp_data};

  assign instr_validD  = ~reset & (fqCount != '0);
  assign instrD        = instr_validD ? fqHead.instr : '0;
  assign PCD           = instr_validD ? fqHead.pc : '0;
  assign PCplus4D      = instr_validD ? next_pc(fqHead.pc) : '0;
  assign unusedTgtBits = ^PCtargetE[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pcF <= RESET_PC;
    end else if (PCSrcE) begin
      pcF <= {PCtargetE[XLEN-1:2], 2'b00};
    end else if (reqFire) begin
      pcF <= next_pc(pcF);
    end
  end

  // On redirect every request still in flight, including one accepted now, is marked for discard.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      outstanding <= outstanding + OW'(reqFire) - OW'(rspCounted);
      if (PCSrcE) begin
        dropCnt <= outstanding + OW'(reqFire) - OW'(rspCounted);
      end else if (rspCounted && dropCnt != '0) begin
        dropCnt <= dropCnt - OW'(1);
      end
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) tagFifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (PCSrcE),
    .push     (reqFire & ~PCSrcE),
    .pushData (pcF),
    .pop      (rspKeep),
    .popData  (tagPc),
    .count    (tagCount)
  );

  fetch_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(FQ_DEPTH)) fetchQueue (
    .clk      (clk),
    .reset    (reset),
    .flush    (PCSrcE),
    .push     (rspKeep),
    .pushData (fqIn),
    .pop      (fqPop),
    .popData  (fqHead),
    .count    (fqCount)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [CW:0] flushInc;
  logic [32:0] flushSum;

  assign flushInc = (PCSrcE ? (CW+1)'(fqCount) : '0) + (CW+1)'(rspDrop);
  assign flushSum = {1'b0, perf_flushedD} + 33'(flushInc);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetchedD <= '0;
      perf_flushedD <= '0;
    end else begin
      if (fqPop && perf_fetchedD != '1) perf_fetchedD <= perf_fetchedD + 32'd1;
      perf_flushedD <= flushSum[32] ? '1 : flushSum[31:0];
    end
  end
`else
  logic unusedDrop;
  assign unusedDrop = rspDrop;
`endif

  // A response with nothing outstanding is ignored by the datapath but flagged in simulation.
  assert property (@(posedge clk) disable iff (reset) !(imem_rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_fetch_unit_q.sv
// Scoreboard bench for fetch_unit_q: directed scenarios, in-order memory model, pop monitor.
module tb_fetch_unit_q;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCtargetE;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_validD;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [31:0] PCplus4D;
  logic        stallD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetchedD;
  logic [31:0] perf_flushedD;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReqT;

  memReqT      memQ[$];
  logic [31:0] expQ[$];
  int          cyc         = 0;
  int          lat         = 1;
  int          popBudget   = 0;
  int          fireCnt     = 0;
  int          testsRun    = 0;
  int          testsFailed = 0;
  bit          holdStall   = 1'b1;
  bit          randReady   = 1'b0;
  bit          randStall   = 1'b0;

  fetch_unit_q dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrcE         (PCSrcE),
    .PCtargetE      (PCtargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_validD   (instr_validD),
    .instrD         (instrD),
    .PCD            (PCD),
    .PCplus4D       (PCplus4D),
    .stallD         (stallD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetchedD  (perf_fetchedD),
    .perf_flushedD  (perf_flushedD)
`endif
  );

  always #5 clk = ~clk;

  // Instruction word stored at each address of the memory model.
  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // One clock: drive memory response, ready and stall for the new cycle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
    PCSrcE = 1'b0;
    if (randReady) imem_req_ready = 1'($urandom_range(0, 1));
    stallD = holdStall || (popBudget == 0) || (randStall && ($urandom_range(0, 1) == 1));
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instrOf(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic expectSeq(input logic [31:0] firstPc, input int n);
    for (int i = 0; i < n; i++) expQ.push_back(firstPc + 32'(4 * i));
  endtask

  task automatic redirect(input logic [31:0] target, input logic [31:0] firstPc, input int n);
    PCSrcE    = 1'b1;
    PCtargetE = target;
    expQ.delete();
    expectSeq(firstPc, n);
  endtask

  task automatic resetDut();
    reset     = 1'b1;
    PCSrcE    = 1'b0;
    PCtargetE = '0;
    popBudget = 0;
    memQ.delete();
    expQ.delete();
    applyStimulus();
    applyStimulus();
    settle();
    checkOutput("rst_instr_valid", 32'(instr_validD), 32'd0);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_pcd", PCD, 32'd0);
    checkOutput("rst_instrd", instrD, 32'd0);
    checkOutput("rst_pcplus4d", PCplus4D, 32'd0);
    applyStimulus();
    reset   = 1'b0;
    fireCnt = 0;
  endtask

  task automatic waitPops(input string name, input int limit);
    for (int i = 0; i < limit && popBudget > 0; i++) applyStimulus();
    applyStimulus();
    settle();
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: records accepted requests for the memory model and scores every pop.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (imem_req_valid && imem_req_ready) begin
        memQ.push_back('{addr: imem_req_addr, due: cyc + lat});
        fireCnt++;
      end
      if (instr_validD && !stallD && !PCSrcE) begin
        if (popBudget > 0) popBudget--;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL sb_extra_pop: got PC %h, required no pop", PCD);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_pc", PCD, e);
          checkOutput("sb_instr", instrD, instrOf(e));
          checkOutput("sb_pcplus4", PCplus4D, e + 32'd4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    reset          = 1'b1;
    PCSrcE         = 1'b0;
    PCtargetE      = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stallD         = 1'b1;

    // Streaming with 1-cycle memory: first valid two cycles after reset, no bubbles.
    lat = 1; imem_req_ready = 1'b1; holdStall = 1'b0;
    resetDut();
    popBudget = 8;
    expectSeq(32'h0, 8);
    settle();
    checkOutput("t1_valid_c0", 32'(instr_validD), 32'd0);
    checkOutput("t1_req_valid_c0", 32'(imem_req_valid), 32'd1);
    checkOutput("t1_req_addr_c0", imem_req_addr, 32'h0);
    applyStimulus();
    settle();
    checkOutput("t1_valid_c1", 32'(instr_validD), 32'd0);
    checkOutput("t1_req_addr_c1", imem_req_addr, 32'h4);
    applyStimulus();
    settle();
    checkOutput("t1_valid_c2", 32'(instr_validD), 32'd1);
    checkOutput("t1_pcd_c2", PCD, 32'h0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus();
      settle();
      checkOutput("t1_no_bubble", 32'(instr_validD), 32'd1);
    end
    waitPops("t1_drain", 20);

    // Decode stalled: credits stop requests at four, then release loses nothing.
    lat = 1; imem_req_ready = 1'b1; holdStall = 1'b1;
    resetDut();
    for (int i = 0; i < 10; i++) applyStimulus();
    settle();
    checkOutput("t2_fire_count", 32'(fireCnt), 32'd4);
    checkOutput("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    checkOutput("t2_head_pc", PCD, 32'h0);
    holdStall = 1'b0;
    popBudget = 8;
    expectSeq(32'h0, 8);
    waitPops("t2_drain", 60);

    // 3-cycle memory, 3 in flight, redirect to 0x100: late responses discarded.
    lat = 3; imem_req_ready = 1'b1; holdStall = 1'b1;
    resetDut();
    applyStimulus();
    applyStimulus();
    applyStimulus();
    imem_req_ready = 1'b0;
    redirect(32'h100, 32'h100, 4);
    applyStimulus();
    imem_req_ready = 1'b1;
    holdStall      = 1'b0;
    popBudget      = 4;
    found          = 1'b0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (instr_validD) begin
        found = 1'b1;
        break;
      end
      applyStimulus();
    end
    checkOutput("t3_valid_seen", 32'(found), 32'd1);
    checkOutput("t3_pcd", PCD, 32'h100);
    checkOutput("t3_pcplus4d", PCplus4D, 32'h104);
    waitPops("t3_drain", 40);

    // Redirect coinciding with request fire and response; misaligned target.
    lat = 2; imem_req_ready = 1'b1; holdStall = 1'b1;
    resetDut();
    applyStimulus();
    applyStimulus();
    redirect(32'h203, 32'h200, 4);
    applyStimulus();
    holdStall = 1'b0;
    popBudget = 4;
    settle();
    checkOutput("t4_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("t4_req_addr", imem_req_addr, 32'h200);
    waitPops("t4_drain", 40);

    // Random ready/stall across the top of the address space.
    lat = 1; imem_req_ready = 1'b0; holdStall = 1'b0;
    resetDut();
    imem_req_ready = 1'b0;
    redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 8);
    randReady = 1'b1;
    randStall = 1'b1;
    popBudget = 8;
    waitPops("t5_drain", 400);
    randReady = 1'b0;
    randStall = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    // Redirect clears two queued entries and one in flight, then twenty pops.
    lat = 2; imem_req_ready = 1'b1; holdStall = 1'b1;
    resetDut();
    applyStimulus();
    applyStimulus();
    imem_req_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    imem_req_ready = 1'b1;
    applyStimulus();
    imem_req_ready = 1'b0;
    redirect(32'h400, 32'h400, 20);
    applyStimulus();
    imem_req_ready = 1'b1;
    holdStall      = 1'b0;
    popBudget      = 20;
    waitPops("t6_drain", 200);
    checkOutput("t6_perf_fetched", perf_fetchedD, 32'd20);
    checkOutput("t6_perf_flushed", perf_flushedD, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
